// File: rtl/exu_pkg.sv
// Shared op codes and FSM encoding for the execute-stage ALU.
// Imported by exu_alu and its iterative multiplier.
package exu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_MUL  = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/exu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first.
// Always runs DATAWIDTH iterations; done pulses for one cycle.
module exu_mul_iter #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 kill,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] product
);

   localparam int CW = $clog2(DATAWIDTH);

   logic [DATAWIDTH-1:0] mcand;
   logic [DATAWIDTH-1:0] mplier;
   logic [DATAWIDTH-1:0] acc;
   logic [CW-1:0]        cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (kill) begin
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b1;
         done   <= 1'b0;
      end else if (busy) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (cnt == CW'(DATAWIDTH - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

   assign product = acc;

endmodule

// File: rtl/exu_alu.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle; MUL runs on exu_mul_iter.
module exu_alu
   import exu_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int MUL_EN    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] src1,
   input  logic [DATAWIDTH-1:0] src2,
   input  logic [DATAWIDTH-1:0] imm,
   input  logic                 use_imm,
   input  logic [3:0]           op,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] result,
   output logic                 illegal
);

   localparam int SHW = $clog2(DATAWIDTH);

   state_t               state;
   state_t               state_nx;
   logic                 accept;
   logic                 is_mul;
   logic                 is_ill;
   logic                 mul_start;
   logic                 mul_busy;
   logic                 mul_done;
   logic [DATAWIDTH-1:0] opb;
   logic [DATAWIDTH-1:0] alu_res;
   logic [DATAWIDTH-1:0] mul_prod;
   logic [SHW-1:0]       shamt;

   assign opb   = use_imm ? imm : src2;
   assign shamt = opb[SHW-1:0];

   // mul_busy is only ever high in BUSY; it also guards a stale run
   assign in_ready = ((state == IDLE) || (state == DONE && out_ready))
                   && !flush && !rst && !mul_busy;
   assign accept   = in_valid && in_ready;
   assign is_mul   = (op == ALU_MUL) && (MUL_EN != 0);
   assign is_ill   = (op > ALU_MUL) || ((op == ALU_MUL) && (MUL_EN == 0));
   assign out_valid = (state == DONE);

   always_comb begin
      alu_res = '0;
      unique case (op)
         ALU_ADD:  alu_res = src1 + opb;
         ALU_SUB:  alu_res = src1 - opb;
         ALU_AND:  alu_res = src1 & opb;
         ALU_OR:   alu_res = src1 | opb;
         ALU_XOR:  alu_res = src1 ^ opb;
         ALU_SLL:  alu_res = src1 << shamt;
         ALU_SRL:  alu_res = src1 >> shamt;
         ALU_SRA:  alu_res = $signed(src1) >>> shamt;
         ALU_SLT:  alu_res = {{(DATAWIDTH-1){1'b0}},
                              ($signed(src1) < $signed(opb))};
         ALU_SLTU: alu_res = {{(DATAWIDTH-1){1'b0}}, (src1 < opb)};
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_nx  = state;
      mul_start = 1'b0;
      if (accept) begin
         state_nx  = is_mul ? BUSY : DONE;
         mul_start = is_mul;
      end else begin
         unique case (state)
            IDLE:    state_nx = IDLE;
            BUSY:    if (mul_done) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
      if (flush) begin
         state_nx  = IDLE;
         mul_start = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         result  <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept && !is_mul) begin
            result  <= is_ill ? '0 : alu_res;
            illegal <= is_ill;
         end else if (state == BUSY && mul_done && !flush) begin
            result  <= mul_prod;
            illegal <= 1'b0;
         end
      end
   end

   if (MUL_EN != 0) begin : g_mul
      exu_mul_iter #(
         .DATAWIDTH(DATAWIDTH)
      ) u_mul (
         .clk     (clk),
         .rst     (rst),
         .start   (mul_start),
         .kill    (flush),
         .a       (src1),
         .b       (opb),
         .busy    (mul_busy),
         .done    (mul_done),
         .product (mul_prod)
      );
   end else begin : g_nomul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
   end

endmodule

// File: doc/exu_alu.md
EXU_ALU -- requirements
Module: exu_alu

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning operand/result width; legal values 8..64, power of two.
REQ-002 SHALL have parameter MUL_EN, default 1, meaning the iterative multiplier is present (0: MUL is an illegal op).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream operation is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operation this cycle.
REQ-007 SHALL have port src1, input, DATAWIDTH, meaning the rs1 operand.
REQ-008 SHALL have port src2, input, DATAWIDTH, meaning the rs2 operand.
REQ-009 SHALL have port imm, input, DATAWIDTH, meaning the immediate operand.
REQ-010 SHALL have port use_imm, input, 1, meaning the second operand is imm instead of src2.
REQ-011 SHALL have port op, input, 4, meaning the operation code from exu_pkg.
REQ-012 SHALL have port flush, input, 1, meaning abort of any in-flight operation.
REQ-013 SHALL have port out_valid, output, 1, meaning result and illegal are valid.
REQ-014 SHALL have port out_ready, input, 1, meaning downstream takes the result this cycle.
REQ-015 SHALL have port result, output, DATAWIDTH, meaning the operation result.
REQ-016 SHALL have port illegal, output, 1, meaning the op was unsupported; result is 0 when set.

Function
REQ-017 SHALL capture op, src1 and the selected operand B (imm if use_imm, else src2) on accept (in_valid && in_ready).
REQ-018 SHALL implement these op codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 SLL, 6 SRL, 7 SRA
- 8 SLT (signed), 9 SLTU (unsigned); both return 0 or 1
- 10 MUL, returning the low DATAWIDTH bits
- 11..15 illegal
REQ-019 SHALL use only the low log2(DATAWIDTH) bits of B as the shift amount; ADD/SUB/MUL wrap modulo 2^DATAWIDTH with no overflow flag.
REQ-020 SHALL implement the FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-021 SHALL use these FSM transitions:
- IDLE + accept of a non-MUL op -> DONE
- IDLE + accept of MUL -> BUSY
- BUSY -> DONE after exactly DATAWIDTH iteration cycles
- DONE + out_ready + no new accept -> IDLE
REQ-022 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready) && !flush.
REQ-023 SHALL, on accept while in DONE, retire the current result and move to DONE or BUSY for the new op in the same edge (back-to-back throughput 1/cycle for non-MUL ops).
REQ-024 SHALL produce the result with latency 1 cycle for non-MUL ops (out_valid high the cycle after accept) and DATAWIDTH+1 cycles for MUL.
REQ-025 SHALL assert out_valid only in DONE, and SHALL hold result and illegal stable while out_valid && !out_ready.
REQ-026 SHALL compute MUL as a shift-add of one multiplier bit per cycle, LSB first; an operand of 0 does not shorten latency.
REQ-027 SHALL apply flush as follows:
- flush in any state -> IDLE next edge, out_valid low, in-flight result discarded
- a simultaneous in_valid is not accepted
REQ-028 SHALL complete an illegal op (including MUL with MUL_EN=0) in 1 cycle with illegal=1 and result=0.

Reset
REQ-029 SHALL, on rst assertion and asynchronously, force state=IDLE, out_valid=0, result=0, illegal=0, and clear the multiplier accumulator and counter.
REQ-030 SHALL discard any in-flight MUL when rst is asserted mid-operation; after release the first accept behaves as from power-up.
REQ-031 SHALL hold in_ready low while rst is high.

Structure
REQ-032 SHALL place the op-code constants (ALU_ADD..ALU_MUL, width 4) and the FSM state encoding in the shared package exu_pkg.
REQ-033 SHALL place the iterative multiplier in one sub-module, exu_mul_iter (start, operands, busy, done, product), parametrised by DATAWIDTH.
REQ-034 SHALL compute the single-cycle ops combinationally on the captured operands, registered into result on the DONE entry edge.

Verification
REQ-035 SHALL cover: ADD src1=0xFFFFFFFF, imm=1, use_imm=1 -> result 0x00000000, out_valid 1 cycle after accept.
REQ-036 SHALL cover: SRA src1=0x80000000, src2=0x24 -> result 0xF8000000 (shift 4); SLT src1=0xFFFFFFFF, src2=1 -> 1; SLTU with the same operands -> 0.
REQ-037 SHALL cover: MUL src1=0x00010001, src2=0x00010001 -> 0x00020001 exactly 33 cycles after accept, in_ready low during BUSY.
REQ-038 SHALL cover: out_ready low for 5 cycles on a SUB 5-7 -> result held at 0xFFFFFFFE; then 4 back-to-back ADDs with out_ready=1 -> one result per cycle.
REQ-039 SHALL cover: flush at BUSY cycle 10 of a MUL -> out_valid never asserts for it; the next ADD 2+3 -> 5.
REQ-040 SHALL cover: op=12 -> illegal=1, result=0; rst pulsed mid-MUL -> out_valid=0 immediately, state IDLE.
